// File: rtl/alu_operand_stage.sv
// ID/EX operand-select stage: per-operand forwarding, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         in_alusrc,
  input  logic [RADDR_W-1:0] in_rs_addr,
  input  logic [RADDR_W-1:0] in_rt_addr,
  input  logic [WIDTH-1:0]   in_rs_data,
  input  logic [WIDTH-1:0]   in_rt_data,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_mem_read,
  input  logic               exmem_wr_en,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_wr_en,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_result,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_input1,
  output logic [WIDTH-1:0]   out_input2,
  output logic [WIDTH-1:0]   out_store_data,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_mem_read,
  output logic               hazard_stall
);

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [RADDR_W-1:0] addr,
    input logic [WIDTH-1:0]   rf_data,
    input logic               ex_we,
    input logic [RADDR_W-1:0] ex_rd,
    input logic [WIDTH-1:0]   ex_res,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [WIDTH-1:0]   wb_res
  );
    if (ex_we && (ex_rd != '0) && (ex_rd == addr))
      return ex_res;
    else if (wb_we && (wb_rd != '0) && (wb_rd == addr))
      return wb_res;
    else
      return rf_data;
  endfunction

  function automatic logic [WIDTH-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
    logic signed [WIDTH-1:0] ext;
    ext = WIDTH'(imm);
    return ext;
  endfunction

  function automatic logic [WIDTH-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(WIDTH-IMM_W){1'b0}}, imm};
  endfunction

  function automatic logic [WIDTH-1:0] upper_imm(input logic [IMM_W-1:0] imm);
    return zext_imm(imm) << 16;
  endfunction

  logic [WIDTH-1:0]   fwd_a, fwd_b, opb;

  logic               valid_q, valid_d;
  logic               mem_read_q, mem_read_d;
  logic [WIDTH-1:0]   input1_q, input1_d;
  logic [WIDTH-1:0]   input2_q, input2_d;
  logic [WIDTH-1:0]   store_q, store_d;
  logic [RADDR_W-1:0] rd_q, rd_d;

  always_comb begin
    fwd_a = fwd_sel(in_rs_addr, in_rs_data, exmem_wr_en, exmem_rd, exmem_result,
                    memwb_wr_en, memwb_rd, memwb_result);
    fwd_b = fwd_sel(in_rt_addr, in_rt_data, exmem_wr_en, exmem_rd, exmem_result,
                    memwb_wr_en, memwb_rd, memwb_result);
    unique case (in_alusrc)
      2'd0:    opb = fwd_b;
      2'd1:    opb = sext_imm(in_imm);
      2'd2:    opb = zext_imm(in_imm);
      default: opb = upper_imm(in_imm);
    endcase
  end

  // rt is compared even for immediate modes: conservative but simple.
  assign hazard_stall = valid_q & mem_read_q & (rd_q != '0) & in_valid &
                        ((rd_q == in_rs_addr) | (rd_q == in_rt_addr));

  always_comb begin
    valid_d    = valid_q;
    mem_read_d = mem_read_q;
    input1_d   = input1_q;
    input2_d   = input2_q;
    store_d    = store_q;
    rd_d       = rd_q;
    if (flush) begin
      valid_d    = 1'b0;
      mem_read_d = 1'b0;
    end else if (stall) begin
      valid_d    = valid_q;
    end else if (hazard_stall) begin
      valid_d    = 1'b0;
      mem_read_d = 1'b0;
    end else begin
      valid_d    = in_valid;
      mem_read_d = in_mem_read & in_valid;
      input1_d   = fwd_a;
      input2_d   = opb;
      store_d    = fwd_b;
      rd_d       = in_rd_addr;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      mem_read_q <= 1'b0;
      input1_q   <= '0;
      input2_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      mem_read_q <= mem_read_d;
      input1_q   <= input1_d;
      input2_q   <= input2_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_mem_read   = mem_read_q;
  assign out_input1     = input1_q;
  assign out_input2     = input2_q;
  assign out_store_data = store_q;
  assign out_rd_addr    = rd_q;

endmodule
